mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; an access issues the cycle after its request is sampled.
// Requesters hold their request and see stall until a one-cycle ready; accesses without mem_ack abort after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int DM_MAX  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        bus_err
);

  localparam int SW = $clog2(DM_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DM_MAX);
  localparam logic [3:0]    WAIT_LAST  = 4'(TIMEOUT - 1);
  localparam logic [31:0]   ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t        state;
  logic [SW-1:0] dm_streak;
  logic [3:0]    wait_cnt;

  logic if_pend;
  logic dm_pend;
  logic dm_win;
  logic expire;

  // A requester whose ready is showing this cycle is still holding its old request.
  assign if_pend = if_req & ~if_ready;
  assign dm_pend = (dm_read | dm_write) & ~dm_ready;
  assign dm_win  = dm_pend & ~(if_pend & (dm_streak == STREAK_MAX));
  assign expire  = (wait_cnt == WAIT_LAST);
  assign stall   = (if_req & ~if_ready) | ((dm_read | dm_write) & ~dm_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      dm_streak <= '0;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_win) begin
            state     <= DM_BUSY;
            mem_en    <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            wait_cnt  <= '0;
            if (dm_read & dm_write) bus_err <= 1'b1;
            if (!if_pend) begin
              dm_streak <= '0;
            end else if (dm_streak != STREAK_MAX) begin
              dm_streak <= dm_streak + 1'b1;
            end
          end else if (if_pend) begin
            state     <= IF_BUSY;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            wait_cnt  <= '0;
            dm_streak <= '0;
          end
        end
        IF_BUSY, DM_BUSY: begin
          // An ack arriving on the expiry cycle still completes normally.
          if (mem_ack || expire) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_ack) bus_err <= 1'b1;
            if (state == IF_BUSY) begin
              if_ready <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : ABORT_DATA;
            end else begin
              dm_ready <= 1'b1;
              if (!mem_we) dm_rdata <= mem_ack ? mem_rdata : ABORT_DATA;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
